// File: rtl/vga_console_pkg.sv
// Shared definitions for the VGA text console: geometry, FSM states,
// control codes and small address helpers.
package vga_console_pkg;

    localparam int COLS      = 80;
    localparam int TEXT_ROWS = 59;

    localparam logic [6:0] CH_BS       = 7'h08;
    localparam logic [6:0] CH_LF       = 7'h0A;
    localparam logic [6:0] CH_FF       = 7'h0C;
    localparam logic [6:0] CH_CR       = 7'h0D;
    localparam logic [6:0] CH_SP       = 7'h20;
    localparam logic [6:0] CH_PRINT_LO = 7'h20;
    localparam logic [6:0] CH_PRINT_HI = 7'h7E;

    typedef enum logic [2:0] {
        CLR_ALL = 3'd0,
        IDLE    = 3'd1,
        PUT     = 3'd2,
        SCRL_RD = 3'd3,
        SCRL_WR = 3'd4,
        CLR_ROW = 3'd5
    } state_t;

    function automatic logic is_printable(input logic [6:0] ch);
        return (ch >= CH_PRINT_LO) && (ch <= CH_PRINT_HI);
    endfunction

    // Cell index to word-aligned byte address inside the char RAM window.
    function automatic logic [31:0] idx_to_addr(input logic [12:0] idx);
        return {17'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/vga_console_if.sv
// Character input stream and char RAM port of the console, bundled so the
// console and its environment see matching directions.
interface vga_console_if;

    logic        in_valid;
    logic [6:0]  in_char;
    logic        in_ready;
    logic        vram_we;
    logic [31:0] vram_addr;
    logic [31:0] vram_wdata;
    logic [6:0]  vram_rdata;

    modport master (
        input  in_valid, in_char, vram_rdata,
        output in_ready, vram_we, vram_addr, vram_wdata
    );

    modport slave (
        output in_valid, in_char, vram_rdata,
        input  in_ready, vram_we, vram_addr, vram_wdata
    );

endinterface

// File: rtl/vga_cell_addr.sv
// Text cell (row, col) to char RAM byte address for an 80-column screen;
// row*80 is built from two shifts so no multiplier is needed.
module vga_cell_addr
    import vga_console_pkg::*;
(
    input  logic [5:0]  row_i,
    input  logic [6:0]  col_i,
    output logic [31:0] addr_o
);

    logic [12:0] idx_s;

    // Shift-add index and its byte address.
    always_comb begin
        idx_s  = ({7'd0, row_i} << 6) + ({7'd0, row_i} << 4) + {6'd0, col_i};
        addr_o = idx_to_addr(idx_s);
    end

endmodule

// File: rtl/vga_console.sv
// Scrolling text console: writes characters into the char RAM, handles
// LF/CR/BS/FF, scrolls the text area and never touches the status row.
module vga_console #(
    parameter int COLS      = vga_console_pkg::COLS,
    parameter int TEXT_ROWS = vga_console_pkg::TEXT_ROWS
) (
    input  logic          sys_clk,
    input  logic          clrn,
    vga_console_if.master bus,
    output logic [5:0]    cursor_row,
    output logic [6:0]    cursor_col
);

    import vga_console_pkg::*;

    localparam logic [12:0] CELLS         = 13'(TEXT_ROWS * COLS);
    localparam logic [12:0] LAST_CELL     = 13'(TEXT_ROWS * COLS - 1);
    localparam logic [12:0] LAST_ROW_BASE = 13'((TEXT_ROWS - 1) * COLS);
    localparam logic [12:0] COLS_W        = 13'(COLS);
    localparam logic [5:0]  ROW_LAST      = 6'(TEXT_ROWS - 1);
    localparam logic [6:0]  COL_LAST      = 7'(COLS - 1);

    state_t      state_q, state_d;
    logic [5:0]  row_q, row_d;
    logic [6:0]  col_q, col_d;
    logic [12:0] cnt_q, cnt_d;
    logic [6:0]  latch_q, latch_d;
    logic        adv_q, adv_d;
    logic        in_ready_q, in_ready_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] cur_addr_s;

    vga_cell_addr u_cell_addr (
        .row_i  (row_d),
        .col_i  (col_d),
        .addr_o (cur_addr_s)
    );

    // Next state, cursor and cell counter (cnt is the source index while scrolling).
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        cnt_d   = cnt_q;
        latch_d = latch_q;
        adv_d   = adv_q;
        case (state_q)
            CLR_ALL: begin
                // we_q low only on the first cycle out of reset: cell 0 not yet issued.
                if (we_q) begin
                    if (cnt_q == LAST_CELL) begin
                        state_d = IDLE;
                        cnt_d   = 13'd0;
                    end else begin
                        cnt_d = cnt_q + 13'd1;
                    end
                end else begin
                    cnt_d = 13'd0;
                end
            end
            IDLE: begin
                if (bus.in_valid) begin
                    if (is_printable(bus.in_char)) begin
                        latch_d = bus.in_char;
                        adv_d   = 1'b1;
                        state_d = PUT;
                    end else begin
                        case (bus.in_char)
                            CH_LF: begin
                                col_d = 7'd0;
                                if (row_q == ROW_LAST) begin
                                    state_d = SCRL_RD;
                                    cnt_d   = COLS_W;
                                end else begin
                                    row_d = row_q + 6'd1;
                                end
                            end
                            CH_CR: col_d = 7'd0;
                            CH_BS: begin
                                if (col_q != 7'd0) begin
                                    col_d   = col_q - 7'd1;
                                    latch_d = CH_SP;
                                    adv_d   = 1'b0;
                                    state_d = PUT;
                                end else begin
                                    col_d = col_q;
                                end
                            end
                            CH_FF: begin
                                row_d   = 6'd0;
                                col_d   = 7'd0;
                                cnt_d   = 13'd0;
                                state_d = CLR_ALL;
                            end
                            default: state_d = IDLE;
                        endcase
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            PUT: begin
                state_d = IDLE;
                if (adv_q && (col_q == COL_LAST)) begin
                    col_d = 7'd0;
                    if (row_q == ROW_LAST) begin
                        state_d = SCRL_RD;
                        cnt_d   = COLS_W;
                    end else begin
                        row_d = row_q + 6'd1;
                    end
                end else if (adv_q) begin
                    col_d = col_q + 7'd1;
                end else begin
                    col_d = col_q;
                end
            end
            SCRL_RD: begin
                latch_d = bus.vram_rdata;
                state_d = SCRL_WR;
            end
            SCRL_WR: begin
                if (cnt_q == LAST_CELL) begin
                    cnt_d   = LAST_ROW_BASE;
                    state_d = CLR_ROW;
                end else begin
                    cnt_d   = cnt_q + 13'd1;
                    state_d = SCRL_RD;
                end
            end
            CLR_ROW: begin
                if (cnt_q == LAST_CELL) begin
                    cnt_d   = 13'd0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 13'd1;
                end
            end
            default: begin
                state_d = CLR_ALL;
                cnt_d   = 13'd0;
            end
        endcase
    end

    // Bus outputs for the coming cycle, decoded from the next state so they register alongside it.
    always_comb begin
        in_ready_d = (state_d == IDLE);
        we_d       = 1'b0;
        addr_d     = 32'd0;
        wdata_d    = 32'd0;
        case (state_d)
            PUT: begin
                we_d    = 1'b1;
                addr_d  = cur_addr_s;
                wdata_d = {25'd0, latch_d};
            end
            SCRL_RD: begin
                addr_d = idx_to_addr(cnt_d);
            end
            SCRL_WR: begin
                we_d    = 1'b1;
                addr_d  = idx_to_addr(cnt_d - COLS_W);
                wdata_d = {25'd0, latch_d};
            end
            CLR_ROW, CLR_ALL: begin
                we_d    = 1'b1;
                addr_d  = idx_to_addr(cnt_d);
                wdata_d = {25'd0, CH_SP};
            end
            default: begin
                we_d    = 1'b0;
                addr_d  = 32'd0;
                wdata_d = 32'd0;
            end
        endcase
    end

    // State, cursor, counters and registered bus outputs.
    always_ff @(posedge sys_clk or negedge clrn) begin
        if (!clrn) begin
            state_q    <= CLR_ALL;
            row_q      <= 6'd0;
            col_q      <= 7'd0;
            cnt_q      <= 13'd0;
            latch_q    <= 7'd0;
            adv_q      <= 1'b0;
            in_ready_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            cnt_q      <= cnt_d;
            latch_q    <= latch_d;
            adv_q      <= adv_d;
            in_ready_q <= in_ready_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.vram_we    = we_q;
    assign bus.vram_addr  = addr_q;
    assign bus.vram_wdata = wdata_q;
    assign cursor_row     = row_q;
    assign cursor_col     = col_q;

endmodule

// File: tb/tb_vga_console.sv
// Randomised scoreboard bench for vga_console: a screen-array model predicts
// every char RAM write and the cursor; a monitor compares writes as they occur.
module tb_vga_console;

    localparam int NC    = 80;
    localparam int NR    = 59;
    localparam int CELLS = NC * NR;

    typedef struct {
        int         idx;
        logic [6:0] ch;
    } wr_t;

    logic       sys_clk = 1'b0;
    logic       clrn;
    logic [5:0] cursor_row;
    logic [6:0] cursor_col;

    vga_console_if vif ();

    vga_console #(.COLS(NC), .TEXT_ROWS(NR)) dut (
        .sys_clk    (sys_clk),
        .clrn       (clrn),
        .bus        (vif.master),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col)
    );

    always #10 sys_clk = ~sys_clk;

    logic [6:0] mem [0:8191];
    logic [6:0] scr [NR][NC];
    wr_t        exp_q [$];
    int         m_row = 0;
    int         m_col = 0;
    int         checks = 0;
    int         errors = 0;
    int         mon_idx;
    wr_t        mon_w;

    assign vif.vram_rdata = mem[vif.vram_addr[14:2]];

    function automatic void check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endfunction

    // ---------------- reference model: screen array + cursor ----------------
    function automatic void m_put(input int r, input int c, input logic [6:0] ch);
        wr_t w;
        w.idx = r * NC + c;
        w.ch  = ch;
        exp_q.push_back(w);
        scr[r][c] = ch;
    endfunction

    function automatic void m_newline();
        m_col = 0;
        if (m_row < NR - 1) begin
            m_row++;
        end else begin
            for (int r = 1; r < NR; r++)
                for (int c = 0; c < NC; c++) m_put(r - 1, c, scr[r][c]);
            for (int c = 0; c < NC; c++) m_put(NR - 1, c, 7'h20);
        end
    endfunction

    function automatic void m_clear_all();
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++) m_put(r, c, 7'h20);
        m_row = 0;
        m_col = 0;
    endfunction

    function automatic void m_accept(input logic [6:0] ch);
        if (ch >= 7'h20 && ch <= 7'h7E) begin
            m_put(m_row, m_col, ch);
            if (m_col == NC - 1) m_newline();
            else m_col++;
        end else if (ch == 7'h0A) begin
            m_newline();
        end else if (ch == 7'h0D) begin
            m_col = 0;
        end else if (ch == 7'h08) begin
            if (m_col > 0) begin
                m_col--;
                m_put(m_row, m_col, 7'h20);
            end
        end else if (ch == 7'h0C) begin
            m_clear_all();
        end
    endfunction

    // ---------------- char RAM model ----------------
    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = (i >= CELLS) ? 7'h55 : 7'h00;
        forever begin
            @(posedge sys_clk);
            if (clrn === 1'b1 && vif.vram_we === 1'b1)
                mem[vif.vram_addr[14:2]] = vif.vram_wdata[6:0];
        end
    end

    // ---------------- monitor: every write against the scoreboard ----------------
    always @(negedge sys_clk) begin
        if (clrn === 1'b1 && vif.vram_we === 1'b1) begin
            mon_idx = int'(vif.vram_addr[14:2]);
            check("write_in_text_area", int'(mon_idx < CELLS), 1);
            check("addr_unused_bits", int'({vif.vram_addr[31:15], vif.vram_addr[1:0]}), 0);
            check("ready_during_write", int'(vif.in_ready), 0);
            if (exp_q.size() == 0) begin
                check("unexpected_write_index", mon_idx, -1);
            end else begin
                mon_w = exp_q.pop_front();
                check("write_index", mon_idx, mon_w.idx);
                check("write_data", int'(vif.vram_wdata), int'(mon_w.ch));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (vif.in_ready !== 1'b1 && n < budget) begin
            @(negedge sys_clk);
            n++;
        end
        check({name, "_idle_reached"}, int'(vif.in_ready === 1'b1), 1);
    endtask

    task automatic check_cursor(input string name);
        check({name, "_row"}, int'(cursor_row), m_row);
        check({name, "_col"}, int'(cursor_col), m_col);
        check({name, "_writes_outstanding"}, exp_q.size(), 0);
    endtask

    // Offer ch, account for it at the accepting edge, check write latency.
    task automatic offer(input logic [6:0] ch, input string name);
        int   n = 0;
        logic wr_now;
        @(negedge sys_clk);
        vif.in_valid = 1'b1;
        vif.in_char  = ch;
        while (vif.in_ready !== 1'b1 && n < 20000) begin
            @(negedge sys_clk);
            n++;
        end
        check({name, "_accept_reached"}, int'(vif.in_ready === 1'b1), 1);
        @(posedge sys_clk);
        wr_now = (ch >= 7'h20 && ch <= 7'h7E) || ch == 7'h0C || (ch == 7'h08 && m_col > 0);
        m_accept(ch);
        #1 vif.in_valid = 1'b0;
        @(negedge sys_clk);
        check({name, "_first_cycle_we"}, int'(vif.vram_we), int'(wr_now));
    endtask

    task automatic send(input logic [6:0] ch, input string name);
        offer(ch, name);
        wait_idle(name, 20000);
        check_cursor(name);
    endtask

    function automatic logic [6:0] rand_char();
        logic [6:0] others [5];
        int         r;
        others = '{7'h00, 7'h07, 7'h09, 7'h1B, 7'h7F};
        r = int'($urandom_range(0, 99));
        if (r < 80) return 7'($urandom_range(32, 126));
        else if (r < 86) return 7'h0A;
        else if (r < 90) return 7'h0D;
        else if (r < 96) return 7'h08;
        else return others[$urandom_range(0, 4)];
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int bad;
        clrn         = 1'b0;
        vif.in_valid = 1'b0;
        vif.in_char  = 7'h00;
        #5;
        check("rst_we", int'(vif.vram_we), 0);
        check("rst_ready", int'(vif.in_ready), 0);
        check("rst_addr", int'(vif.vram_addr), 0);
        check("rst_wdata", int'(vif.vram_wdata), 0);
        check("rst_row", int'(cursor_row), 0);
        check("rst_col", int'(cursor_col), 0);
        m_clear_all();
        repeat (3) @(negedge sys_clk);
        clrn = 1'b1;
        wait_idle("init_clear", 6000);
        check_cursor("init_clear");

        send(7'h41, "put_A");
        send(7'h0D, "cr");
        for (int i = 0; i < 3; i++) send(7'h0A, "lf_down");
        for (int i = 0; i < 79; i++) send(7'($urandom_range(32, 126)), "fill_row3");
        send(7'h5A, "wrap_Z");

        send(7'h0C, "form_feed");
        send(7'h0A, "lf_a");
        send(7'h0A, "lf_b");
        send(7'h08, "bs_col0");
        send(7'h61, "put_a");
        send(7'h62, "put_b");
        send(7'h63, "put_c");
        send(7'h08, "bs_col3");

        for (int i = 0; i < 56; i++) send(7'h0A, "lf_to_bottom");
        for (int i = 0; i < 5; i++) send(7'($urandom_range(32, 126)), "fill_row58");
        send(7'h0A, "scroll_lf");
        send(7'h5E, "after_scroll");

        // Start another scroll, then pull reset mid-way with a character held.
        send(7'h0A, "lf_no_scroll_col");
        offer(7'h0A, "scroll_abort");
        repeat (1000) @(negedge sys_clk);
        check("scroll_busy_before_reset", int'(vif.in_ready), 0);
        #3 clrn = 1'b0;
        #1;
        check("abort_we", int'(vif.vram_we), 0);
        check("abort_ready", int'(vif.in_ready), 0);
        check("abort_row", int'(cursor_row), 0);
        check("abort_col", int'(cursor_col), 0);
        exp_q.delete();
        m_clear_all();
        vif.in_valid = 1'b1;
        vif.in_char  = 7'h51;
        repeat (3) @(negedge sys_clk);
        clrn = 1'b1;
        send(7'h51, "held_char");

        for (int i = 0; i < 150; i++) send(rand_char(), "random");

        bad = 0;
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++)
                if (mem[r * NC + c] !== scr[r][c]) bad++;
        check("screen_cells_differing", bad, 0);
        bad = 0;
        for (int i = CELLS; i < CELLS + NC; i++)
            if (mem[i] !== 7'h55) bad++;
        check("status_row_cells_touched", bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #4000000;
        $display("FAIL watchdog simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vga_console.md
VGA_CONSOLE -- requirements
Module: vga_console

Interface
REQ-001 SHALL have parameter COLS, default 80, characters per row.
REQ-002 SHALL have parameter TEXT_ROWS, default 59, scrolling text rows; row 59 is the status row and this block never writes it.
REQ-003 SHALL have port sys_clk, input, 1, the single clock (50 MHz); one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clrn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, character offered.
REQ-006 SHALL have port in_char, input, 7, ASCII code.
REQ-007 SHALL have port in_ready, output, 1, character accepted when in_valid and in_ready are both high on a sys_clk edge.
REQ-008 SHALL have port vram_we, output, 1, char RAM write strobe, wvram-compatible.
REQ-009 SHALL have port vram_addr, output, 32, byte address; cell index on bits [14:2], all other bits 0.
REQ-010 SHALL have port vram_wdata, output, 32, write data; bits [6:0] carry the char, bits [31:7] are 0.
REQ-011 SHALL have port vram_rdata, input, 7, combinational char RAM read of vram_addr.
REQ-012 SHALL have port cursor_row, output, 6, current row.
REQ-013 SHALL have port cursor_col, output, 7, current column.

Function
REQ-014 SHALL compute cell index = row*80 + col as (row<<6)+(row<<4)+col, 13 bits, with no overflow for legal coordinates.
REQ-015 SHALL implement states CLR_ALL, IDLE, PUT, SCRL_RD, SCRL_WR, CLR_ROW, all registered.
REQ-016 SHALL drive in_ready high only in IDLE.
REQ-017 SHALL drive vram_we high only in PUT, SCRL_WR, CLR_ROW and CLR_ALL.
REQ-018 Printable code (0x20-0x7E) accepted in IDLE: SHALL go to PUT; the next cycle writes in_char at the cursor.
REQ-019 After the PUT write, SHALL advance col; at col=COLS-1, SHALL set col=0 and advance row.
REQ-020 LF (0x0A): SHALL set col=0 and advance row, with no write.
REQ-021 CR (0x0D): SHALL set col=0.
REQ-022 BS (0x08): if col>0, SHALL decrement col and enter PUT writing 0x20 without advancing; if col=0, SHALL do nothing.
REQ-023 FF (0x0C): SHALL enter CLR_ALL and home the cursor to (0,0).
REQ-024 Any other code SHALL be accepted and discarded; state stays IDLE.
REQ-025 Row advance from row TEXT_ROWS-1: row SHALL stay TEXT_ROWS-1 and the block SHALL enter SCRL_RD with src=COLS and dst=0.
REQ-026 SCRL_RD: vram_addr=src, vram_we=0, vram_rdata latched.
REQ-027 SCRL_WR: vram_addr=dst, write latched data; increment src and dst; when src reaches TEXT_ROWS*COLS, go to CLR_ROW.
REQ-028 Scroll SHALL take 2 cycles per cell, 9280 cycles for the defaults.
REQ-029 CLR_ROW: SHALL write 0x20 to cells (TEXT_ROWS-1)*COLS..TEXT_ROWS*COLS-1, one per cycle, then return to IDLE.
REQ-030 CLR_ALL: SHALL write 0x20 to cells 0..TEXT_ROWS*COLS-1, one per cycle (4720 cycles), then go to IDLE.
REQ-031 SHALL never address a cell at or above TEXT_ROWS*COLS (status row 59 is protected).
REQ-032 in_valid while in_ready=0 SHALL be ignored, with no buffering; the source holds the character.
REQ-033 cursor_row and cursor_col SHALL reflect the updated position from the cycle after acceptance, or after the PUT write for printable codes.

Reset
REQ-034 clrn low SHALL asynchronously force state=CLR_ALL, clear counter=0, cursor=(0,0), vram_we=0, in_ready=0, vram_addr=0, vram_wdata=0, and the latch=0.
REQ-035 Reset asserted mid-scroll or mid-clear SHALL abandon the operation; after release, a full CLR_ALL runs before IDLE.

Structure
REQ-036 The shared package vga_console_pkg SHALL hold COLS, TEXT_ROWS, the state enum, and constants CH_LF, CH_CR, CH_BS, CH_FF, CH_SP.
REQ-037 A single sub-module vga_cell_addr (row, col -> 32-bit byte address) SHALL be used, shareable with other VGA text blocks.
REQ-038 The top level SHALL ensure the CPU does not write the char RAM while vram_we is high; this block does not arbitrate.

Verification
REQ-039 Release reset, hold in_valid low: exactly 4720 writes of 0x20 to indices 0..4719, then in_ready=1 and cursor=(0,0).
REQ-040 Send 'A' (0x41) at (0,0): one write of 0x41 to vram_addr 0x0000 one cycle after accept; cursor becomes (0,1).
REQ-041 At (3,79) send 'Z': write to index 319 (vram_addr 0x04FC); cursor becomes (4,0).
REQ-042 At (58,5) send LF: 4640 read/write pairs with cell 80 copied to 0, then 80 writes of 0x20 to indices 4640..4719; cursor becomes (58,0); index 4720+ is never touched.
REQ-043 At (2,0) send BS: no write, cursor unchanged; at (2,3) send BS: write 0x20 to index 162, cursor becomes (2,2).
REQ-044 Pulse clrn low during a scroll: vram_we drops immediately; after release, CLR_ALL restarts at index 0; in_valid held high stays unaccepted until in_ready=1.
